// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared opcodes, FSM state encoding and immediate helper for the fetch/exec control unit
// Ports: none (package).
package cu_pkg;

    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_JUMP  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10,
        HALT  = 2'b11
    } cu_state_t;

    // Sign-extends the low imm_w bits of imm to 32 bits (1 <= imm_w <= 31).
    // The caller truncates to its own address width.
    function automatic logic [31:0] sext_imm(input logic [31:0] imm, input int imm_w);
        logic signed [31:0] shifted;
        shifted = $signed(imm << (32 - imm_w));
        return shifted >>> (32 - imm_w);
    endfunction

endpackage

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - combinational opcode decode and next-PC computation
// Ports:
//   ir        in   IW  latched instruction word
//   pc        in   AW  current program counter
//   is_write  out  1   opcode is a register write
//   is_jump   out  1   opcode is a jump
//   next_pc   out  AW  PC after this instruction retires
//   self_jump out  1   jump whose target equals the current PC
module cu_decode
    import cu_pkg::*;
#(
    parameter int IW        = 8,
    parameter int AW        = 8,
    parameter int JUMP_MODE = 1
) (
    input  logic [IW-1:0] ir,
    input  logic [AW-1:0] pc,
    output logic          is_write,
    output logic          is_jump,
    output logic [AW-1:0] next_pc,
    output logic          self_jump
);

    logic [1:0]    opcode;
    logic [31:0]   imm_raw;
    logic [AW-1:0] simm;
    logic [AW-1:0] target;

    assign opcode  = ir[IW-1:IW-2];
    assign imm_raw = 32'(ir[IW-3:0]);
    // Sign extension happens at full 32 bits first so a wide immediate
    // is truncated to AW only after its sign has been propagated.
    assign simm    = AW'(sext_imm(imm_raw, IW - 2));

    assign is_write = (opcode == OP_WRITE);
    assign is_jump  = (opcode == OP_JUMP);

    assign target    = (JUMP_MODE != 0) ? (pc + simm) : simm;
    assign next_pc   = is_jump ? target : (pc + AW'(1));
    assign self_jump = is_jump && (target == pc);

endmodule

// File: rtl/cu_fetch_seq.sv
// rtl/cu_fetch_seq.sv - fetch/exec sequencer owning the PC of the accumulator CPU
// Ports:
//   clk, rst_n   in   clock, asynchronous active-low reset
//   imem_req     out  fetch request, high throughout FETCH
//   imem_addr    out  fetch address (= pc)
//   imem_valid   in   instruction present on imem_data (sampled in FETCH only)
//   imem_data    in   instruction word
//   stall        in   datapath back-pressure, holds EXEC
//   write_en     out  register write strobe for the retiring write instruction
//   pc           out  current program counter
//   halted       out  core stopped on a self-jump
//   retired      out  saturating executed-instruction count
module cu_fetch_seq
    import cu_pkg::*;
#(
    parameter int            IW        = 8,
    parameter int            AW        = 8,
    parameter int            JUMP_MODE = 1,
    parameter logic [AW-1:0] RESET_PC  = '0,
    parameter int            CNTW      = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [AW-1:0]   imem_addr,
    input  logic            imem_valid,
    input  logic [IW-1:0]   imem_data,
    input  logic            stall,
    output logic            write_en,
    output logic [AW-1:0]   pc,
    output logic            halted,
    output logic [CNTW-1:0] retired
);

    cu_state_t     state;
    logic [IW-1:0] ir;

    logic          is_write;
    logic          is_jump;
    logic [AW-1:0] next_pc;
    logic          self_jump;
    logic          retire;
    logic          go_halt;

    cu_decode #(
        .IW        (IW),
        .AW        (AW),
        .JUMP_MODE (JUMP_MODE)
    ) u_decode (
        .ir        (ir),
        .pc        (pc),
        .is_write  (is_write),
        .is_jump   (is_jump),
        .next_pc   (next_pc),
        .self_jump (self_jump)
    );

    assign imem_addr = pc;
    assign retire    = (state == EXEC) && !stall;
    assign go_halt   = is_jump && self_jump;
    // Combinational so the strobe lands in exactly the cycle the stall releases.
    assign write_en  = retire && is_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ir       <= '0;
            pc       <= RESET_PC;
            retired  <= '0;
            imem_req <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_valid) begin
                        ir       <= imem_data;
                        state    <= EXEC;
                        imem_req <= 1'b0;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        if (!(&retired)) begin
                            retired <= retired + CNTW'(1);
                        end
                        if (go_halt) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            pc       <= next_pc;
                            state    <= FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    state    <= HALT;
                    imem_req <= 1'b0;
                    halted   <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cu_fetch_seq.sv
// tb/tb_cu_fetch_seq.sv - directed self-checking bench for cu_fetch_seq
module tb_cu_fetch_seq;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [7:0]  imem_data;
    logic        stall;
    logic        write_en;
    logic [7:0]  pc;
    logic        halted;
    logic [15:0] retired;

    logic        auto_valid;
    logic        valid_force;
    logic [7:0]  mem [256];

    logic        rst_n_sat;
    logic        req_sat;
    logic [7:0]  addr_sat;
    logic        we_sat;
    logic [7:0]  pc_sat;
    logic        halted_sat;
    logic [3:0]  retired_sat;

    int checks;
    int errors;

    assign imem_data  = mem[imem_addr];
    assign imem_valid = auto_valid ? imem_req : valid_force;

    cu_fetch_seq #(.IW(8), .AW(8), .JUMP_MODE(1), .RESET_PC(8'h00), .CNTW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .stall      (stall),
        .write_en   (write_en),
        .pc         (pc),
        .halted     (halted),
        .retired    (retired)
    );

    cu_fetch_seq #(.IW(8), .AW(8), .JUMP_MODE(1), .RESET_PC(8'h00), .CNTW(4)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n_sat),
        .imem_req   (req_sat),
        .imem_addr  (addr_sat),
        .imem_valid (1'b1),
        .imem_data  (8'h00),
        .stall      (1'b0),
        .write_en   (we_sat),
        .pc         (pc_sat),
        .halted     (halted_sat),
        .retired    (retired_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_clear();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        load_clear();
        stall = 1'b0; auto_valid = 1'b1; valid_force = 1'b0;
        rst_n = 1'b0;
        tick(2);
        checks++;
        if (pc !== 8'h00 || imem_req !== 1'b0 || write_en !== 1'b0 || halted !== 1'b0 || retired !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: pc=%h req=%b we=%b halted=%b retired=%0d, need 00 0 0 0 0",
                     pc, imem_req, write_en, halted, retired);
        end
    endtask

    task automatic test_write_op();
        int we_cnt;
        load_clear();
        mem[8'h00] = 8'h80;
        mem[8'h01] = 8'hC0;
        do_reset();
        we_cnt = 0;
        tick(1);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL first_fetch: req=%b addr=%h, need 1 00", imem_req, imem_addr);
        end
        tick(1);
        checks++;
        if (write_en !== 1'b1) begin
            errors++;
            $display("FAIL write_pulse: we=%b, need 1", write_en);
        end
        we_cnt += int'(write_en);
        tick(1);
        checks++;
        if (pc !== 8'h01 || retired !== 16'd1) begin
            errors++;
            $display("FAIL write_retire: pc=%h retired=%0d, need 01 1", pc, retired);
        end
        for (int i = 0; i < 6; i++) begin
            we_cnt += int'(write_en);
            tick(1);
        end
        checks++;
        if (we_cnt != 1) begin
            errors++;
            $display("FAIL write_pulse_count: got %0d, need 1", we_cnt);
        end
    endtask

    task automatic test_rel_jump();
        int we_cnt;
        load_clear();
        mem[8'h00] = 8'hC5;
        mem[8'h05] = 8'hC3;
        mem[8'h08] = 8'hC0;
        do_reset();
        we_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            we_cnt += int'(write_en);
        end
        checks++;
        if (pc !== 8'h08 || imem_addr !== 8'h08 || imem_req !== 1'b1 || we_cnt != 0) begin
            errors++;
            $display("FAIL rel_jump: pc=%h addr=%h req=%b we_cnt=%0d, need 08 08 1 0",
                     pc, imem_addr, imem_req, we_cnt);
        end
    endtask

    task automatic test_wrap();
        load_clear();
        mem[8'h00] = 8'hC1;
        mem[8'h01] = 8'hFE;
        mem[8'hFF] = 8'h00;
        do_reset();
        tick(5);
        checks++;
        if (pc !== 8'hFF || imem_addr !== 8'hFF) begin
            errors++;
            $display("FAIL neg_jump: pc=%h addr=%h, need ff ff", pc, imem_addr);
        end
        tick(2);
        checks++;
        if (pc !== 8'h00 || retired !== 16'd3) begin
            errors++;
            $display("FAIL pc_wrap: pc=%h retired=%0d, need 00 3", pc, retired);
        end
    endtask

    task automatic test_halt();
        int req_seen;
        load_clear();
        mem[8'h00] = 8'hC7;
        mem[8'h07] = 8'hC0;
        do_reset();
        tick(5);
        checks++;
        if (halted !== 1'b1 || pc !== 8'h07 || retired !== 16'd2) begin
            errors++;
            $display("FAIL halt_entry: halted=%b pc=%h retired=%0d, need 1 07 2", halted, pc, retired);
        end
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (imem_req !== 1'b0 || write_en !== 1'b0) req_seen++;
        end
        checks++;
        if (req_seen != 0 || retired !== 16'd2 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_hold: active_cycles=%0d retired=%0d halted=%b, need 0 2 1",
                     req_seen, retired, halted);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || pc !== 8'h00 || retired !== 16'd0) begin
            errors++;
            $display("FAIL halt_reset: halted=%b pc=%h retired=%0d, need 0 00 0", halted, pc, retired);
        end
        tick(1);
        rst_n = 1'b1;
    endtask

    task automatic test_stall();
        int bad;
        load_clear();
        mem[8'h00] = 8'h80;
        mem[8'h01] = 8'hC0;
        stall = 1'b1;
        do_reset();
        tick(1);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (write_en !== 1'b0 || pc !== 8'h00 || retired !== 16'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: bad_cycles=%0d, need 0", bad);
        end
        stall = 1'b0;
        #1;
        checks++;
        if (write_en !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_pulse: we=%b, need 1", write_en);
        end
        tick(1);
        checks++;
        if (write_en !== 1'b0 || pc !== 8'h01 || retired !== 16'd1) begin
            errors++;
            $display("FAIL stall_retire: we=%b pc=%h retired=%0d, need 0 01 1", write_en, pc, retired);
        end
    endtask

    task automatic test_async_reset();
        load_clear();
        mem[8'h00] = 8'h80;
        do_reset();
        tick(3);
        auto_valid = 1'b0;
        valid_force = 1'b0;
        tick(4);
        checks++;
        if (imem_req !== 1'b1 || pc !== 8'h01 || retired !== 16'd1) begin
            errors++;
            $display("FAIL fetch_wait: req=%b pc=%h retired=%0d, need 1 01 1", imem_req, pc, retired);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc !== 8'h00 || retired !== 16'd0 || write_en !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: req=%b pc=%h retired=%0d we=%b, need 0 00 0 0",
                     imem_req, pc, retired, write_en);
        end
        valid_force = 1'b1;
        tick(2);
        valid_force = 1'b0;
        rst_n = 1'b1;
        tick(3);
        checks++;
        if (imem_req !== 1'b1 || retired !== 16'd0 || pc !== 8'h00) begin
            errors++;
            $display("FAIL stale_valid: req=%b retired=%0d pc=%h, need 1 0 00", imem_req, retired, pc);
        end
        auto_valid = 1'b1;
    endtask

    task automatic test_saturation();
        rst_n_sat = 1'b0;
        tick(2);
        rst_n_sat = 1'b1;
        tick(29);
        checks++;
        if (retired_sat !== 4'd14) begin
            errors++;
            $display("FAIL sat_before: retired=%0d, need 14", retired_sat);
        end
        tick(2);
        checks++;
        if (retired_sat !== 4'd15) begin
            errors++;
            $display("FAIL sat_reach: retired=%0d, need 15", retired_sat);
        end
        tick(10);
        checks++;
        if (retired_sat !== 4'd15 || pc_sat !== 8'h14 || halted_sat !== 1'b0) begin
            errors++;
            $display("FAIL sat_hold: retired=%0d pc=%h halted=%b, need 15 14 0",
                     retired_sat, pc_sat, halted_sat);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        rst_n_sat = 1'b0;
        stall = 1'b0;
        auto_valid = 1'b1;
        valid_force = 1'b0;
        test_reset();
        test_write_op();
        test_rel_jump();
        test_wrap();
        test_halt();
        test_stall();
        test_async_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
